obi_bank_arbiter: RTL and testbench
===================================

// Module: obi_bank_arbiter
// PURPOSE
// - Shares one OBI slave (one RAM bank, or the CSR port) between NMASTER OBI masters.
// - Used in front of each ram_req_o bank and wrapper_csr_req_o when several
//   harts or accelerators need a private path that bypasses the system crossbar.
// - Round-robin arbitration on the address phase.
// - Holds the arbitration decision stable until the slave grants it.
// - Routes each response back to its issuer through an in-order grant-index FIFO.
// PARAMETERS
// - NMASTER          default 3  number of requesting masters (>=2)
// - MAX_OUTSTANDING  default 2  depth of the grant-index FIFO (>=1): max granted, unanswered txns
// - IDX_W            default $clog2(NMASTER)  derived, not overridden
// PORTS
// - clk_i              in   1        system clock
// - rst_ni             in   1        asynchronous active-low reset
// - master_req_i       in   NMASTER x obi_req_t   requests from masters
// - master_resp_o      out  NMASTER x obi_resp_t  gnt/rvalid/rdata to masters
// - slave_req_o        out  obi_req_t             request to shared slave
// - slave_resp_i       in   obi_resp_t            gnt/rvalid/rdata from shared slave
// - busy_o             out  1        FIFO non-empty or request pending
// - spurious_rvalid_o  out  1        1-cycle pulse: slave rvalid while FIFO empty
// BEHAVIOUR
// - Reset (async, rst_ni=0):
//   - rr_ptr=0, lock=0, lock_idx=0, FIFO empty.
//   - All outputs are 0: slave_req_o, master_resp_o, busy_o, spurious_rvalid_o.
// - Selection (combinational):
//   - If lock=1: sel=lock_idx.
//   - Else: sel = first i with master_req_i[i].req, scanning rr_ptr, rr_ptr+1, ... mod NMASTER.
// - Forwarding:
//   - slave_req_o = master_req_i[sel] when a request is selected and the FIFO is not full.
//   - Otherwise slave_req_o = all-zero.
//   - FIFO full blocks forwarding even if a pop happens in the same cycle.
// - Grant:
//   - master_resp_o[sel].gnt = slave_resp_i.gnt while forwarding.
//   - gnt=0 for every other master.
//   - Zero extra latency: the grant is combinational.
// - Lock:
//   - Forwarding with slave gnt=0 -> next lock=1, lock_idx=sel.
//   - Any forwarded grant -> lock=0.
//   - Guarantees addr/we/be/wdata do not switch to another master before gnt, per OBI.
// - On grant (forwarding && slave gnt):
//   - Push sel into the FIFO.
//   - rr_ptr <= (sel==NMASTER-1) ? 0 : sel+1.
// - Response:
//   - If slave_resp_i.rvalid and FIFO non-empty:
//     - master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata; pop.
//     - All other masters: rvalid=0, rdata=0.
// - Spurious response:
//   - rvalid with FIFO empty: dropped; spurious_rvalid_o=1 in that cycle; no state change.
// - Simultaneous grant and rvalid: push and pop in the same cycle; count unchanged.
// - Responses are strictly in grant order; the slave must answer in order (SRAM: rvalid 1 cycle after gnt).
// - Fairness: a continuously requesting master waits at most NMASTER-1 grants.
// - FIFO:
//   - Circular, wr/rd pointers wrap at MAX_OUTSTANDING-1 -> 0.
//   - Count width $clog2(MAX_OUTSTANDING+1).
// - busy_o = (count!=0) | lock | any master_req_i[i].req; combinational.
// - Reset mid-transaction:
//   - All state clears immediately.
//   - Responses arriving after reset release count as spurious.
// TESTING
// - Single master: M0 reads 0x0000_0010; slave gnt same cycle, rvalid+rdata=0xDEADBEEF next cycle.
//   -> M0 gnt in cycle 0; M0 rvalid with 0xDEADBEEF in cycle 1; M1/M2 never see gnt or rvalid.
// - Round-robin: M0, M1, M2 request continuously; slave always grants.
//   -> grant order 0,1,2,0,1,2; rr_ptr after grant 3 = 0.
// - Lock: M1 selected, slave gnt=0 for 3 cycles, M0 raises req in cycle 1.
//   -> slave_req_o stays M1 addr/wdata for all 3 cycles; M0 is granted only after M1.
// - FIFO full (MAX_OUTSTANDING=2): two grants, rvalid withheld.
//   -> slave_req_o.req=0 despite pending M2 req.
//   -> first rvalid returns to the first grantee; the next cycle forwards M2.
// - Back-to-back grant+rvalid: grant M2 in the same cycle rvalid answers M0.
//   -> count unchanged, M0 receives rdata, M2 entry queued.
// - Spurious/reset: rvalid with FIFO empty -> spurious_rvalid_o=1 for 1 cycle, no master rvalid.
//   - Assert rst_ni=0 with 2 outstanding -> busy_o=0, all gnt/rvalid=0 immediately.

Source files
------------

// File: rtl/obi_bank_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : obi_bank_arbiter
// Brief    : Round-robin sharing of one OBI slave between NMASTER masters;
//            responses are steered back through an in-order grant-index FIFO.
// Revision : 1.0
// =============================================================================

package obi_bank_arbiter_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_bank_arbiter
   import obi_bank_arbiter_pkg::*;
#(
   parameter int NMASTER         = 3,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  obi_req_t  master_req_i  [NMASTER],
   output obi_resp_t master_resp_o [NMASTER],
   output obi_req_t  slave_req_o,
   input  obi_resp_t slave_resp_i,
   output logic      busy_o,
   output logic      spurious_rvalid_o
);

   localparam int IDX_W   = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

   logic [IDX_W-1:0]   r_rr_ptr;
   logic               r_lock;
   logic [IDX_W-1:0]   r_lock_idx;
   logic [IDX_W-1:0]   r_fifo [MAX_OUTSTANDING];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   logic [NMASTER-1:0] w_req_vec;
   logic [IDX_W-1:0]   w_sel;
   logic               w_found;
   logic               w_full;
   logic               w_empty;
   logic               w_fwd;
   logic               w_push;
   logic               w_pop;

   for (genvar g = 0; g < NMASTER; g++) begin : g_req_vec
      assign w_req_vec[g] = master_req_i[g].req;
   end

   function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reverse scan so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      logic [IDX_W:0] cand;
      cand    = '0;
      w_sel   = r_lock_idx;
      w_found = r_lock;
      if (!r_lock) begin
         for (int k = NMASTER - 1; k >= 0; k--) begin
            cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NMASTER)) begin
               cand = cand - (IDX_W+1)'(NMASTER);
            end
            if (w_req_vec[cand[IDX_W-1:0]]) begin
               w_sel   = cand[IDX_W-1:0];
               w_found = 1'b1;
            end
         end
      end
   end

   assign w_full  = (r_count == c_cnt_w'(MAX_OUTSTANDING));
   assign w_empty = (r_count == '0);
   assign w_fwd   = rst_ni & w_found & w_req_vec[w_sel] & ~w_full;
   assign w_push  = w_fwd & slave_resp_i.gnt;
   assign w_pop   = rst_ni & slave_resp_i.rvalid & ~w_empty;

   always_comb begin
      slave_req_o = w_fwd ? master_req_i[w_sel] : '0;
      for (int i = 0; i < NMASTER; i++) begin
         master_resp_o[i] = '0;
      end
      if (w_fwd) begin
         master_resp_o[w_sel].gnt = slave_resp_i.gnt;
      end
      if (w_pop) begin
         master_resp_o[r_fifo[r_rd_ptr]].rvalid = 1'b1;
         master_resp_o[r_fifo[r_rd_ptr]].rdata  = slave_resp_i.rdata;
      end
   end

   // Outputs are forced low while reset is held, not just after the next edge.
   assign busy_o            = rst_ni & ((r_count != '0) | r_lock | (|w_req_vec));
   assign spurious_rvalid_o = rst_ni & slave_resp_i.rvalid & w_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr   <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         if (w_fwd) begin
            r_lock     <= ~slave_resp_i.gnt;
            r_lock_idx <= w_sel;
         end
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= next_ptr(r_wr_ptr);
            r_rr_ptr         <= (w_sel == IDX_W'(NMASTER - 1)) ? '0 : w_sel + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_obi_bank_arbiter.sv
`default_nettype none
// Testbench for obi_bank_arbiter: directed scenarios followed by randomized
// traffic compared against a queue-based reference model.
module tb_obi_bank_arbiter;
   import obi_bank_arbiter_pkg::*;

   localparam int NM   = 3;
   localparam int MAXO = 2;

   logic      clk_i = 1'b0;
   logic      rst_ni;
   obi_req_t  master_req_i  [NM];
   obi_resp_t master_resp_o [NM];
   obi_req_t  slave_req_o;
   obi_resp_t slave_resp_i;
   logic      busy_o;
   logic      spurious_rvalid_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   obi_bank_arbiter #(.NMASTER(NM), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .master_req_i      (master_req_i),
      .master_resp_o     (master_resp_o),
      .slave_req_o       (slave_req_o),
      .slave_resp_i      (slave_resp_i),
      .busy_o            (busy_o),
      .spurious_rvalid_o (spurious_rvalid_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < NM; i++) master_req_i[i] = '0;
      slave_resp_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   function automatic obi_req_t mk_req(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic we);
      obi_req_t r;
      r.req = 1'b1; r.we = we; r.be = 4'hF; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   function automatic logic [NM-1:0] gnt_vec();
      logic [NM-1:0] v;
      for (int i = 0; i < NM; i++) v[i] = master_resp_o[i].gnt;
      return v;
   endfunction

   function automatic logic [NM-1:0] rvalid_vec();
      logic [NM-1:0] v;
      for (int i = 0; i < NM; i++) v[i] = master_resp_o[i].rvalid;
      return v;
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      for (int i = 0; i < NM; i++) master_req_i[i] = mk_req(32'h40 + 32'(i), 32'h1234, 1'b1);
      slave_resp_i.gnt = 1'b1; slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hCAFE;
      #3;
      checks++; if (slave_req_o !== '0) begin errors++; $display("FAIL reset_slave_req: got %h expected 0", slave_req_o); end
      for (int i = 0; i < NM; i++) begin
         checks++; if (master_resp_o[i] !== '0) begin errors++; $display("FAIL reset_resp[%0d]: got %h expected 0", i, master_resp_o[i]); end
      end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (spurious_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b expected 0", spurious_rvalid_o); end
      do_reset();
   endtask

   task automatic test_single_master();
      obi_req_t e0;
      do_reset();
      e0 = mk_req(32'h0000_0010, 32'h0, 1'b0);
      master_req_i[0] = e0;
      slave_resp_i.gnt = 1'b1;
      @(negedge clk_i);
      checks++; if (slave_req_o !== e0) begin errors++; $display("FAIL single_fwd: got %h expected %h", slave_req_o, e0); end
      checks++; if (gnt_vec() !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", gnt_vec()); end
      tick();
      master_req_i[0] = '0;
      slave_resp_i.gnt = 1'b0; slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hDEADBEEF;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b001) begin errors++; $display("FAIL single_rvalid: got %b expected 001", rvalid_vec()); end
      checks++; if (master_resp_o[0].rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", master_resp_o[0].rdata); end
      checks++; if (gnt_vec() !== 3'b000) begin errors++; $display("FAIL single_no_gnt: got %b expected 000", gnt_vec()); end
      checks++; if (spurious_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_spurious: got %b expected 0", spurious_rvalid_o); end
      tick();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      int exp_order[6] = '{0, 1, 2, 0, 1, 2};
      logic [NM-1:0] e;
      do_reset();
      for (int i = 0; i < NM; i++) master_req_i[i] = mk_req(32'h100 + 32'(i * 4), 32'(i), 1'b0);
      slave_resp_i.gnt = 1'b1;
      for (int c = 0; c < 6; c++) begin
         slave_resp_i.rvalid = (c > 0);
         slave_resp_i.rdata  = 32'hA000_0000 + 32'(c);
         @(negedge clk_i);
         e = NM'(1 << exp_order[c]);
         checks++; if (gnt_vec() !== e) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt_vec(), e); end
         checks++; if (slave_req_o.addr !== 32'h100 + 32'(exp_order[c] * 4)) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", c, slave_req_o.addr, 32'h100 + 32'(exp_order[c] * 4)); end
         if (c > 0) begin
            e = NM'(1 << exp_order[c-1]);
            checks++; if (rvalid_vec() !== e) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", c, rvalid_vec(), e); end
         end
         tick();
      end
      idle_inputs();
      slave_resp_i.rvalid = 1'b1;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b100) begin errors++; $display("FAIL rr_drain: got %b expected 100", rvalid_vec()); end
      tick();
      idle_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_lock();
      obi_req_t a0, a1;
      do_reset();
      a1 = mk_req(32'h2000, 32'h1111_1111, 1'b1);
      a0 = mk_req(32'h3000, 32'h2222_2222, 1'b1);
      master_req_i[1] = a1;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) master_req_i[0] = a0;
         @(negedge clk_i);
         checks++; if (slave_req_o !== a1) begin errors++; $display("FAIL lock_hold[%0d]: got %h expected %h", c, slave_req_o, a1); end
         checks++; if (gnt_vec() !== 3'b000) begin errors++; $display("FAIL lock_nognt[%0d]: got %b expected 000", c, gnt_vec()); end
         tick();
      end
      slave_resp_i.gnt = 1'b1;
      @(negedge clk_i);
      checks++; if (slave_req_o !== a1) begin errors++; $display("FAIL lock_final: got %h expected %h", slave_req_o, a1); end
      checks++; if (gnt_vec() !== 3'b010) begin errors++; $display("FAIL lock_gnt_m1: got %b expected 010", gnt_vec()); end
      tick();
      master_req_i[1] = '0;
      slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'h5555_0001;
      @(negedge clk_i);
      checks++; if (slave_req_o !== a0) begin errors++; $display("FAIL lock_next_m0: got %h expected %h", slave_req_o, a0); end
      checks++; if (gnt_vec() !== 3'b001) begin errors++; $display("FAIL lock_gnt_m0: got %b expected 001", gnt_vec()); end
      checks++; if (rvalid_vec() !== 3'b010) begin errors++; $display("FAIL lock_rvalid_m1: got %b expected 010", rvalid_vec()); end
      tick();
      master_req_i[0] = '0;
      slave_resp_i.gnt = 1'b0; slave_resp_i.rdata = 32'h5555_0002;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b001) begin errors++; $display("FAIL lock_rvalid_m0: got %b expected 001", rvalid_vec()); end
      tick();
      idle_inputs();
   endtask

   task automatic test_fifo_full();
      obi_req_t a2;
      do_reset();
      a2 = mk_req(32'h4008, 32'h3333_3333, 1'b0);
      master_req_i[0] = mk_req(32'h4000, 32'h0, 1'b0);
      master_req_i[1] = mk_req(32'h4004, 32'h0, 1'b0);
      master_req_i[2] = a2;
      slave_resp_i.gnt = 1'b1;
      @(negedge clk_i);
      checks++; if (gnt_vec() !== 3'b001) begin errors++; $display("FAIL full_g0: got %b expected 001", gnt_vec()); end
      tick();
      master_req_i[0] = '0;
      @(negedge clk_i);
      checks++; if (gnt_vec() !== 3'b010) begin errors++; $display("FAIL full_g1: got %b expected 010", gnt_vec()); end
      tick();
      master_req_i[1] = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         checks++; if (slave_req_o.req !== 1'b0) begin errors++; $display("FAIL full_block[%0d]: got %b expected 0", c, slave_req_o.req); end
         checks++; if (gnt_vec() !== 3'b000) begin errors++; $display("FAIL full_nognt[%0d]: got %b expected 000", c, gnt_vec()); end
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy[%0d]: got %b expected 1", c, busy_o); end
         tick();
      end
      slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hF1;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b001) begin errors++; $display("FAIL full_pop_m0: got %b expected 001", rvalid_vec()); end
      checks++; if (master_resp_o[0].rdata !== 32'hF1) begin errors++; $display("FAIL full_rdata: got %h expected f1", master_resp_o[0].rdata); end
      checks++; if (slave_req_o.req !== 1'b0) begin errors++; $display("FAIL full_pop_block: got %b expected 0", slave_req_o.req); end
      tick();
      slave_resp_i.rvalid = 1'b0;
      @(negedge clk_i);
      checks++; if (slave_req_o !== a2) begin errors++; $display("FAIL full_fwd_m2: got %h expected %h", slave_req_o, a2); end
      checks++; if (gnt_vec() !== 3'b100) begin errors++; $display("FAIL full_gnt_m2: got %b expected 100", gnt_vec()); end
      tick();
      master_req_i[2] = '0;
      slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hF2;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b010) begin errors++; $display("FAIL full_pop_m1: got %b expected 010", rvalid_vec()); end
      tick();
      slave_resp_i.rdata = 32'hF3;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b100) begin errors++; $display("FAIL full_pop_m2: got %b expected 100", rvalid_vec()); end
      tick();
      idle_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_idle: got %b expected 0", busy_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      master_req_i[0] = mk_req(32'h5000, 32'h0, 1'b0);
      slave_resp_i.gnt = 1'b1;
      @(negedge clk_i);
      checks++; if (gnt_vec() !== 3'b001) begin errors++; $display("FAIL b2b_g0: got %b expected 001", gnt_vec()); end
      tick();
      master_req_i[0] = '0;
      master_req_i[2] = mk_req(32'h5008, 32'h0, 1'b0);
      slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hD000_0000;
      @(negedge clk_i);
      checks++; if (gnt_vec() !== 3'b100) begin errors++; $display("FAIL b2b_g2: got %b expected 100", gnt_vec()); end
      checks++; if (rvalid_vec() !== 3'b001) begin errors++; $display("FAIL b2b_r0: got %b expected 001", rvalid_vec()); end
      checks++; if (master_resp_o[0].rdata !== 32'hD000_0000) begin errors++; $display("FAIL b2b_rdata0: got %h expected d0000000", master_resp_o[0].rdata); end
      checks++; if (master_resp_o[2].rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata2_zero: got %h expected 0", master_resp_o[2].rdata); end
      tick();
      master_req_i[2] = '0;
      slave_resp_i.rdata = 32'hD000_0002;
      @(negedge clk_i);
      checks++; if (rvalid_vec() !== 3'b100) begin errors++; $display("FAIL b2b_r2: got %b expected 100", rvalid_vec()); end
      checks++; if (master_resp_o[2].rdata !== 32'hD000_0002) begin errors++; $display("FAIL b2b_rdata2: got %h expected d0000002", master_resp_o[2].rdata); end
      checks++; if (spurious_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_spurious: got %b expected 0", spurious_rvalid_o); end
      tick();
      idle_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy_o); end
   endtask

   task automatic test_spurious_reset();
      do_reset();
      slave_resp_i.rvalid = 1'b1; slave_resp_i.rdata = 32'hBAD;
      @(negedge clk_i);
      checks++; if (spurious_rvalid_o !== 1'b1) begin errors++; $display("FAIL spur_pulse: got %b expected 1", spurious_rvalid_o); end
      checks++; if (rvalid_vec() !== 3'b000) begin errors++; $display("FAIL spur_no_rvalid: got %b expected 000", rvalid_vec()); end
      tick();
      slave_resp_i.rvalid = 1'b0;
      @(negedge clk_i);
      checks++; if (spurious_rvalid_o !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b expected 0", spurious_rvalid_o); end
      master_req_i[0] = mk_req(32'h6000, 32'h0, 1'b0);
      master_req_i[1] = mk_req(32'h6004, 32'h0, 1'b0);
      slave_resp_i.gnt = 1'b1;
      tick();
      tick();
      @(negedge clk_i);
      checks++; if (slave_req_o.req !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL spur_two_outstanding: got req=%b busy=%b expected req=0 busy=1", slave_req_o.req, busy_o); end
      slave_resp_i.rvalid = 1'b1;
      #1 rst_ni = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
      checks++; if (gnt_vec() !== 3'b000 || rvalid_vec() !== 3'b000) begin errors++; $display("FAIL rst_mid_resp: got gnt=%b rvalid=%b expected 000/000", gnt_vec(), rvalid_vec()); end
      checks++; if (slave_req_o !== '0) begin errors++; $display("FAIL rst_mid_slave: got %h expected 0", slave_req_o); end
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < NM; i++) master_req_i[i] = '0;
      slave_resp_i.gnt = 1'b0;
      @(negedge clk_i);
      checks++; if (spurious_rvalid_o !== 1'b1) begin errors++; $display("FAIL rst_late_spurious: got %b expected 1", spurious_rvalid_o); end
      checks++; if (rvalid_vec() !== 3'b000) begin errors++; $display("FAIL rst_late_rvalid: got %b expected 000", rvalid_vec()); end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      int unsigned m_rr;
      bit          m_lock;
      int unsigned m_lock_idx;
      int unsigned m_q[$];
      bit          done[NM];
      int unsigned sel;
      bit          found, fwd, any_req, exp_busy, exp_spur;
      obi_req_t    exp_req;
      obi_resp_t   exp_resp[NM];
      do_reset();
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_q.delete();
      for (int i = 0; i < NM; i++) done[i] = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         // masters keep a request stable until it is granted
         for (int i = 0; i < NM; i++) begin
            if (!master_req_i[i].req || done[i]) begin
               master_req_i[i].req   = ($urandom_range(0, 2) != 0);
               master_req_i[i].we    = 1'($urandom);
               master_req_i[i].be    = 4'($urandom);
               master_req_i[i].addr  = $urandom;
               master_req_i[i].wdata = $urandom;
               done[i] = 1'b0;
            end
         end
         slave_resp_i.gnt    = 1'($urandom);
         slave_resp_i.rdata  = $urandom;
         slave_resp_i.rvalid = (m_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 15) == 0);

         found = 1'b0; sel = 0;
         if (m_lock) begin
            sel = m_lock_idx; found = 1'b1;
         end else begin
            for (int k = 0; k < NM; k++) begin
               if (!found && master_req_i[(m_rr + k) % NM].req) begin
                  sel = (m_rr + k) % NM; found = 1'b1;
               end
            end
         end
         fwd = found && master_req_i[sel].req && (m_q.size() < MAXO);
         exp_req = fwd ? master_req_i[sel] : '0;
         any_req = 1'b0;
         for (int i = 0; i < NM; i++) begin
            any_req = any_req | master_req_i[i].req;
            exp_resp[i] = '0;
         end
         if (fwd) exp_resp[sel].gnt = slave_resp_i.gnt;
         if (slave_resp_i.rvalid && m_q.size() > 0) begin
            exp_resp[m_q[0]].rvalid = 1'b1;
            exp_resp[m_q[0]].rdata  = slave_resp_i.rdata;
         end
         exp_spur = slave_resp_i.rvalid && (m_q.size() == 0);
         exp_busy = (m_q.size() != 0) || m_lock || any_req;

         @(negedge clk_i);
         checks++; if (slave_req_o !== exp_req) begin errors++; $display("FAIL rand_slave_req[%0d]: got %h expected %h", c, slave_req_o, exp_req); end
         for (int i = 0; i < NM; i++) begin
            checks++; if (master_resp_o[i] !== exp_resp[i]) begin errors++; $display("FAIL rand_resp[%0d][%0d]: got %h expected %h", c, i, master_resp_o[i], exp_resp[i]); end
         end
         checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy_o, exp_busy); end
         checks++; if (spurious_rvalid_o !== exp_spur) begin errors++; $display("FAIL rand_spurious[%0d]: got %b expected %b", c, spurious_rvalid_o, exp_spur); end

         if (slave_resp_i.rvalid && m_q.size() > 0) void'(m_q.pop_front());
         if (fwd && slave_resp_i.gnt) begin
            m_q.push_back(sel);
            m_rr = (sel + 1) % NM;
            done[sel] = 1'b1;
         end
         if (fwd) begin
            m_lock     = !slave_resp_i.gnt;
            m_lock_idx = sel;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      test_reset();
      test_single_master();
      test_round_robin();
      test_lock();
      test_fifo_full();
      test_back_to_back();
      test_spurious_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
